coproc_scheduler: RTL
=====================

Name: coproc_scheduler

Overview:
Issues FPU and crypto-core operations from the Decode stage of the 16-bit pipelined CPU and tracks their completion. Holds finished results in per-unit buffers. Shares the single register-file write port between the main pipeline's Writeback stage and the two coprocessors. Keeps an 8-entry register scoreboard and stalls Decode on data hazards and on busy units.

Parameters:
NREG, 8, architectural registers tracked; the register index is log2(NREG) = 3 bits
DW, 16, datapath width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
dec_valid  in  1  valid instruction in Decode, not flushed
dec_is_cp  in  1  Decode instruction is a coprocessor op
dec_unit  in  1  target unit: 0 = FPU, 1 = crypto
dec_rd  in  3  destination register
dec_rs1  in  3  source register 1
dec_rs2  in  3  source register 2
dec_uses_rs2  in  1  rs2 is a real operand
dec_op_a  in  16  forwarded operand A
dec_op_b  in  16  forwarded operand B
dec_funct3  in  3  sub-operation
stall_in  in  1  stall from the main hazard unit
RegwriteW  in  1  main pipeline write enable
RdW  in  3  main pipeline write address
ResultW  in  16  main pipeline write data
stallD  out  1  stall Fetch/Decode
fpu_start  out  1  one-cycle start pulse
crypto_start  out  1  one-cycle start pulse
cp_op_a  out  16  latched operand A
cp_op_b  out  16  latched operand B
cp_funct3  out  3  latched sub-operation
fpu_done  in  1  FPU result valid, one-cycle pulse
fpu_result  in  16  FPU result
crypto_done  in  1  crypto result valid, one-cycle pulse
crypto_result  in  16  crypto result
rf_wr_en  out  1  register-file write enable
rf_wr_addr  out  3  register-file write address
rf_wr_data  out  16  register-file write data
cp_busy  out  1  any unit not IDLE (clock-gating hint)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low.
- Reset values: all registered state is cleared. Scoreboard = 0; both unit FSMs = IDLE; starts = 0; cp_op_a/cp_op_b/cp_funct3 = 0; round-robin pointer = FPU; cp_busy = 0.
- While rst is low, rf_wr_en, stallD, fpu_start and crypto_start are forced to 0 combinationally.
- Scoreboard: pend[7:0]; bit r set means a coprocessor result for register r is outstanding.
- Hazard stall: haz is asserted when dec_valid and any of the following hold:
  - pend[dec_rs1];
  - dec_uses_rs2 and pend[dec_rs2];
  - pend[dec_rd] (WAW).
  - This applies to all instructions, not only coprocessor ops.
- Unit stall: ustall = dec_valid & dec_is_cp & (target unit FSM != IDLE).
- stallD = haz | ustall.
- Issue condition: dec_valid & dec_is_cp & !stallD & !stall_in.
- Issue actions, registered, visible on the next cycle:
  - the target unit's start pulses high for exactly 1 cycle;
  - cp_op_a, cp_op_b and cp_funct3 are captured;
  - pend[dec_rd] is set;
  - the unit's rd tag is stored;
  - the unit FSM goes IDLE -> BUSY.
- Unit FSM (one per unit): IDLE -> BUSY on issue; BUSY -> HOLD on done, capturing the result into the unit buffer; HOLD -> IDLE when the buffer is written back.
  - done while IDLE or HOLD is ignored.
  - A unit in HOLD cannot accept a new issue until the cycle after its writeback.
- Write-port arbitration (combinational):
  - Priority 1: RegwriteW = 1 -> rf_wr_* = {1, RdW, ResultW}; no coprocessor buffer drains that cycle.
  - Priority 2: otherwise, if exactly one unit is in HOLD, that unit's buffer drives rf_wr_*.
  - If both units are in HOLD, the round-robin pointer selects the unit; the pointer then flips to the other unit.
  - On a drain, pend[tag] clears at the clock edge and the unit FSM returns to IDLE.
  - Minimum latency, done pulse -> register-file write: 1 cycle (buffer capture, write on the following cycle), absent main-pipeline writes.
- Simultaneous events:
  - A set and a clear of the scoreboard in the same cycle always target different registers, guaranteed by the WAW stall.
  - Issue to one unit and drain of the other unit in the same cycle are both permitted.
- cp_busy = (FPU FSM != IDLE) | (crypto FSM != IDLE).
- Reset mid-operation: everything returns to reset values. A done pulse arriving after reset is ignored (unit is IDLE).

Test Plan:
- FPU issue: dec_rd=3, op_a=0x1234 -> fpu_start=1 for 1 cycle, cp_op_a=0x1234, pend[3]=1. fpu_done with result 0xBEEF 4 cycles later, RegwriteW=0 -> rf_wr_en=1, addr=3, data=0xBEEF on the next cycle; pend[3]=0 afterwards.
- RAW: with pend[3]=1, Decode ALU instruction has rs1=3 -> stallD=1 until the writeback cycle completes, then 0. rs2=3 with dec_uses_rs2=0 -> no stall.
- Unit busy: second FPU op while FPU is BUSY -> stallD=1, no fpu_start. A crypto op issued in the same window -> crypto_start=1.
- Port conflict: both units in HOLD (rd=2 and rd=5) with RegwriteW=1 for 2 cycles -> main writes win. Then FPU (rd=2) drains, next cycle crypto (rd=5) drains; pointer = FPU afterwards.
- Flush and stall: dec_valid=0 or stall_in=1 with a coprocessor op -> no start pulse, pend unchanged.
- Reset mid-op: rst low while FPU is BUSY -> pend=0, outputs 0. A later fpu_done -> no write.

Source files
------------

// File: rtl/coproc_scheduler.sv
// Coprocessor issue/completion scheduler for the 16-bit pipelined CPU.
// Issues FPU and crypto operations from Decode, buffers their results,
// shares the register-file write port with Writeback and keeps a
// per-register scoreboard used to stall Decode on hazards.
module coproc_scheduler #(
    parameter int unsigned NREG = 8,
    parameter int unsigned DW   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_valid,
    input  logic                     dec_is_cp,
    input  logic                     dec_unit,
    input  logic [$clog2(NREG)-1:0]  dec_rd,
    input  logic [$clog2(NREG)-1:0]  dec_rs1,
    input  logic [$clog2(NREG)-1:0]  dec_rs2,
    input  logic                     dec_uses_rs2,
    input  logic [DW-1:0]            dec_op_a,
    input  logic [DW-1:0]            dec_op_b,
    input  logic [2:0]               dec_funct3,
    input  logic                     stall_in,
    input  logic                     RegwriteW,
    input  logic [$clog2(NREG)-1:0]  RdW,
    input  logic [DW-1:0]            ResultW,
    output logic                     stallD,
    output logic                     fpu_start,
    output logic                     crypto_start,
    output logic [DW-1:0]            cp_op_a,
    output logic [DW-1:0]            cp_op_b,
    output logic [2:0]               cp_funct3,
    input  logic                     fpu_done,
    input  logic [DW-1:0]            fpu_result,
    input  logic                     crypto_done,
    input  logic [DW-1:0]            crypto_result,
    output logic                     rf_wr_en,
    output logic [$clog2(NREG)-1:0]  rf_wr_addr,
    output logic [DW-1:0]            rf_wr_data,
    output logic                     cp_busy
);

    localparam int unsigned RW = $clog2(NREG);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_HOLD
    } unit_state_t;

    unit_state_t       r_fpu_st, w_fpu_st_nxt;
    unit_state_t       r_cry_st, w_cry_st_nxt;
    logic [NREG-1:0]   r_pend, w_pend_nxt;
    logic [RW-1:0]     r_fpu_tag, r_cry_tag;
    logic [DW-1:0]     r_fpu_buf, r_cry_buf;
    logic              r_rr;          // 0: FPU wins next tie, 1: crypto
    logic              r_fpu_start, r_cry_start;
    logic [DW-1:0]     r_op_a, r_op_b;
    logic [2:0]        r_funct3;

    logic w_haz, w_tgt_busy, w_ustall, w_stall;
    logic w_issue, w_issue_fpu, w_issue_cry;
    logic w_fpu_hold, w_cry_hold, w_drain_fpu, w_drain_cry;

    assign w_haz       = dec_valid & (r_pend[dec_rs1] | (dec_uses_rs2 & r_pend[dec_rs2]) | r_pend[dec_rd]);
    assign w_tgt_busy  = dec_unit ? (r_cry_st != ST_IDLE) : (r_fpu_st != ST_IDLE);
    assign w_ustall    = dec_valid & dec_is_cp & w_tgt_busy;
    assign w_stall     = w_haz | w_ustall;
    assign w_issue     = dec_valid & dec_is_cp & ~w_stall & ~stall_in;
    assign w_issue_fpu = w_issue & ~dec_unit;
    assign w_issue_cry = w_issue & dec_unit;
    assign w_fpu_hold  = (r_fpu_st == ST_HOLD);
    assign w_cry_hold  = (r_cry_st == ST_HOLD);

    assign stallD       = rst & w_stall;
    assign fpu_start    = rst & r_fpu_start;
    assign crypto_start = rst & r_cry_start;
    assign cp_op_a      = r_op_a;
    assign cp_op_b      = r_op_b;
    assign cp_funct3    = r_funct3;
    assign cp_busy      = (r_fpu_st != ST_IDLE) | (r_cry_st != ST_IDLE);

    // Choose which held buffer drains; Writeback always takes the port first
    always_comb begin
        w_drain_fpu = 1'b0;
        w_drain_cry = 1'b0;
        if (!RegwriteW) begin
            if (w_fpu_hold && w_cry_hold) begin
                w_drain_fpu = ~r_rr;
                w_drain_cry = r_rr;
            end else begin
                w_drain_fpu = w_fpu_hold;
                w_drain_cry = w_cry_hold;
            end
        end
    end

    // Register-file write port mux, suppressed while in reset
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        if (RegwriteW) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = RdW;
            rf_wr_data = ResultW;
        end else if (w_drain_fpu) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = r_fpu_tag;
            rf_wr_data = r_fpu_buf;
        end else if (w_drain_cry) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = r_cry_tag;
            rf_wr_data = r_cry_buf;
        end
        if (!rst) begin
            rf_wr_en = 1'b0;
        end
    end

    // Scoreboard update: clear on drain, set on issue (never the same register)
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_drain_fpu) w_pend_nxt[r_fpu_tag] = 1'b0;
        if (w_drain_cry) w_pend_nxt[r_cry_tag] = 1'b0;
        if (w_issue)     w_pend_nxt[dec_rd]    = 1'b1;
    end

    // FPU unit next-state
    always_comb begin
        w_fpu_st_nxt = r_fpu_st;
        case (r_fpu_st)
            ST_IDLE: if (w_issue_fpu) w_fpu_st_nxt = ST_BUSY;
            ST_BUSY: if (fpu_done)    w_fpu_st_nxt = ST_HOLD;
            ST_HOLD: if (w_drain_fpu) w_fpu_st_nxt = ST_IDLE;
            default: w_fpu_st_nxt = ST_IDLE;
        endcase
    end

    // Crypto unit next-state
    always_comb begin
        w_cry_st_nxt = r_cry_st;
        case (r_cry_st)
            ST_IDLE: if (w_issue_cry) w_cry_st_nxt = ST_BUSY;
            ST_BUSY: if (crypto_done) w_cry_st_nxt = ST_HOLD;
            ST_HOLD: if (w_drain_cry) w_cry_st_nxt = ST_IDLE;
            default: w_cry_st_nxt = ST_IDLE;
        endcase
    end

    // Unit state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpu_st <= ST_IDLE;
            r_cry_st <= ST_IDLE;
        end else begin
            r_fpu_st <= w_fpu_st_nxt;
            r_cry_st <= w_cry_st_nxt;
        end
    end

    // Issue latches, result buffers, scoreboard and arbitration pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend      <= '0;
            r_fpu_tag   <= '0;
            r_cry_tag   <= '0;
            r_fpu_buf   <= '0;
            r_cry_buf   <= '0;
            r_rr        <= 1'b0;
            r_fpu_start <= 1'b0;
            r_cry_start <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_funct3    <= '0;
        end else begin
            r_pend      <= w_pend_nxt;
            r_fpu_start <= w_issue_fpu;
            r_cry_start <= w_issue_cry;
            if (w_issue) begin
                r_op_a   <= dec_op_a;
                r_op_b   <= dec_op_b;
                r_funct3 <= dec_funct3;
            end
            if (w_issue_fpu) r_fpu_tag <= dec_rd;
            if (w_issue_cry) r_cry_tag <= dec_rd;
            if ((r_fpu_st == ST_BUSY) && fpu_done)    r_fpu_buf <= fpu_result;
            if ((r_cry_st == ST_BUSY) && crypto_done) r_cry_buf <= crypto_result;
            // pointer always points away from the unit that drained last
            if (w_drain_fpu)      r_rr <= 1'b1;
            else if (w_drain_cry) r_rr <= 1'b0;
        end
    end

endmodule
